gray_conv_arbiter: RTL

- Shares one binary/Gray conversion datapath between NREQ requesters.
- The datapath is one nbtg (binary->Gray) and one ngtb (Gray->binary) instance, both at width SIZE.
- Each requester submits a SIZE-bit word plus a direction bit over valid/ready. A round-robin arbiter grants one request per cycle.
- The converted word comes back through a single registered response port tagged with the requester id. The response port supports backpressure.

---
 rtl/gray_conv_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/gray_conv_arbiter.sv
// Shared binary/Gray conversion datapath with a round-robin front end.
// NREQ requesters compete for one nbtg/ngtb pair; the converted word
// returns through a single registered, backpressured response port.

// Binary -> Gray: each Gray bit is the XOR of adjacent binary bits.
module nbtg #(
    parameter int size = 10
) (
    input  logic [size-1:0] bin_i,
    output logic [size-1:0] gray_o
);
    assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// Gray -> binary: binary bit i is the XOR of all Gray bits at or above i.
module ngtb #(
    parameter int size = 10
) (
    input  logic [size-1:0] gray_i,
    output logic [size-1:0] bin_o
);
    // Prefix-XOR from the MSB down, written per bit to avoid a comb loop.
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < size; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end
endmodule

// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold valid/mode/data until their ready bit is seen;
// ready never depends on valid of the same requester except via arbitration,
// and rsp_ready reaches req_ready only through can_accept.
module gray_conv_arbiter #(
    parameter int SIZE = 10,
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_mode,
    input  logic [NREQ*SIZE-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [SIZE-1:0]      rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_mode
);
    // Response register occupancy is the whole state machine.
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic            state_q, state_d;
    logic [SIZE-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic            rsp_mode_q, rsp_mode_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;

    logic [IDW-1:0]  gnt;
    logic            gnt_found;
    logic            can_accept;
    logic            accept;
    logic [SIZE-1:0] sel_data;
    logic            sel_mode;
    logic [SIZE-1:0] gray_w;
    logic [SIZE-1:0] bin_w;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!gnt_found && req_valid[(int'(last_grant_q) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt       = IDW'((int'(last_grant_q) + k) % NREQ);
            end
        end
    end

    // Accept when a winner exists and the response slot is free or draining;
    // held off entirely while reset is asserted.
    always_comb begin
        can_accept = (state_q == ST_EMPTY) || rsp_ready;
        accept     = gnt_found && can_accept && rst_n;
        req_ready  = accept ? (NREQ'(1) << gnt) : '0;
    end

    // Only the granted word enters the datapath; idle cycles feed zero.
    always_comb begin
        sel_data = gnt_found ? req_data[int'(gnt)*SIZE +: SIZE] : '0;
        sel_mode = gnt_found ? req_mode[gnt] : 1'b0;
    end

    nbtg #(.size(SIZE)) u_nbtg (.bin_i(sel_data), .gray_o(gray_w));
    ngtb #(.size(SIZE)) u_ngtb (.gray_i(sel_data), .bin_o(bin_w));

    // Load on accept (replacing any draining result), clear on bare drain.
    always_comb begin
        state_d      = state_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_mode_d   = rsp_mode_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            state_d      = ST_FULL;
            rsp_data_d   = sel_mode ? bin_w : gray_w;
            rsp_id_d     = gnt;
            rsp_mode_d   = sel_mode;
            last_grant_d = gnt;
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Response register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            rsp_mode_q   <= 1'b0;
            last_grant_q <= IDW'(NREQ - 1);
        end else begin
            state_q      <= state_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_mode_q   <= rsp_mode_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_mode  = rsp_mode_q;
endmodule
